// File: rtl/seq_div8_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// iteration-counter sizing.
package seq_div8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter wide enough to hold the iteration count WIDTH itself.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_div8_bit_sub.sv
// Single-bit full-subtractor cell: D = A - B - Bin_in with borrow out.
module bit_sub (
  input  logic A,
  input  logic B,
  input  logic Bin_in,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin_in;
  assign Bout = (~A & B) | (~(A ^ B) & Bin_in);

endmodule

// File: rtl/seq_div8.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, using a
// ripple-borrow chain of bit_sub cells for the trial subtraction.
module seq_div8
  import seq_div8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dbz
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, nxt;
  logic [WIDTH-1:0] dvd, dvs, quo, rem;
  logic [CW-1:0]    cnt;
  logic             zero;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] diff;
  logic             diff_top_unused;
  logic [WIDTH+1:0] brw;
  logic             last;

  assign shifted = {rem, dvd[WIDTH-1]};
  assign trial   = {1'b0, dvs};
  assign brw[0]  = 1'b0;
  assign last    = (cnt == CW'(WIDTH - 1));

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_sub
      bit_sub u_cell (
        .A      (shifted[i]),
        .B      (trial[i]),
        .Bin_in (brw[i]),
        .D      (diff[i]),
        .Bout   (brw[i+1])
      );
    end
  endgenerate

  // Top cell only matters for its borrow; its difference bit is always 0 when kept.
  bit_sub u_cell_top (
    .A      (shifted[WIDTH]),
    .B      (trial[WIDTH]),
    .Bin_in (brw[WIDTH]),
    .D      (diff_top_unused),
    .Bout   (brw[WIDTH+1])
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (Bin != '0) ? RUN : DONE;
      RUN:     if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // Working registers are loaded on accept; results publish as DONE exits,
  // together with the registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      Q    <= '0;
      R    <= '0;
      dbz  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          dvd  <= Ain;
          dvs  <= Bin;
          rem  <= '0;
          quo  <= '0;
          cnt  <= '0;
          zero <= (Bin == '0);
        end
        RUN: begin
          rem <= brw[WIDTH+1] ? shifted[WIDTH-1:0] : diff;
          quo <= {quo[WIDTH-2:0], ~brw[WIDTH+1]};
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          Q   <= zero ? '1  : quo;
          R   <= zero ? dvd : rem;
          dbz <= zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div8.sv
// Self-checking bench for seq_div8: directed cases plus a random sweep compared
// against a plain-arithmetic division model.
module tb_seq_div8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] Ain, Bin, Q, R;
  logic         busy, done, dbz;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] pq, pr;

  always #5 clk = ~clk;

  seq_div8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Ain   (Ain),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .dbz   (dbz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    Ain   = a;
    Bin   = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the cycle index (0 = cycle after accept) at which done shows, -1 on timeout.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
      chk("hold_q", 32'(Q), 32'(pq));
      chk("hold_r", 32'(R), 32'(pr));
    end
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    int           lat, bcnt;
    logic [W-1:0] eq, er;
    logic         ed;
    if (b == 0) begin
      eq = {W{1'b1}}; er = a; ed = 1'b1;
    end else begin
      eq = a / b; er = a % b; ed = 1'b0;
    end
    issue(a, b);
    wait_done(lat, bcnt);
    chk("latency", 32'(lat), (b == 0) ? 32'd1 : 32'(W + 1));
    chk("busy_cycles", 32'(bcnt), (b == 0) ? 32'd0 : 32'(W));
    chk("q", 32'(Q), 32'(eq));
    chk("r", 32'(R), 32'(er));
    chk("dbz", 32'(dbz), 32'(ed));
    if (b != 0) begin
      chk("invariant", 32'(Q) * 32'(b) + 32'(R), 32'(a));
      chk("r_lt_b", 32'(R < b), 32'd1);
    end
    pq = Q;
    pr = R;
  endtask

  initial begin
    int pulses, lat, bcnt;
    logic [W-1:0] cq, cr;
    rst = 1'b1; start = 1'b0; Ain = '0; Bin = '0;
    pq = '0; pr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_r", 32'(R), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);

    op(8'd200, 8'd7);
    op(8'd255, 8'd1);
    op(8'd5, 8'd9);
    op(8'd0, 8'd3);

    // Second start arrives on the third RUN cycle and must be dropped.
    issue(8'd100, 8'd10);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; Ain = 8'd50; Bin = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0; cq = '0; cr = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        cq = Q;
        cr = R;
      end
    end
    chk("ignore_pulses", 32'(pulses), 32'd1);
    chk("ignore_q", 32'(cq), 32'd10);
    chk("ignore_r", 32'(cr), 32'd0);
    pq = Q; pr = R;

    op(8'd13, 8'd0);

    // Reset on the fourth RUN cycle aborts the operation.
    issue(8'd200, 8'd7);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", 32'(Q), 32'd0);
    chk("abort_r", 32'(R), 32'd0);
    chk("abort_dbz", 32'(dbz), 32'd0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort_idle", 32'(pulses), 32'd0);
    pq = '0; pr = '0;
    op(8'd9, 8'd2);

    // Back-to-back random sweep.
    for (int n = 0; n < 1000; n++) begin
      op(W'($urandom_range(255, 0)), W'($urandom_range(255, 1)));
    end
    @(negedge clk);
    chk("single_pulse", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
